// File: rtl/cpu_pipe_pkg.sv
// Shared decode/pipeline definitions: register address width, forward
// select encoding and the scoreboard entry layout.
package cpu_pipe_pkg;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int FWD_RF         = 0;

  typedef struct packed {
    logic                      valid;
    logic [DEF_REG_ADDR_W-1:0] dst;
    logic                      is_load;
  } sb_entry_t;
endpackage

// File: rtl/hazard_src_match.sv
// Per-source scoreboard scan: picks the youngest in-flight writer of the
// source register and turns it into a bypass select or a stall request.
module hazard_src_match
  import cpu_pipe_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic [REG_ADDR_W-1:0]                 src,
  input  logic                                  used,
  input  logic [NUM_STAGES-1:0]                 vld_pipe,
  input  logic [NUM_STAGES-1:0][REG_ADDR_W-1:0] dst_pipe,
  input  logic [NUM_STAGES-1:0]                 ld_pipe,
  output logic                                  stall_req,
  output logic [SEL_W-1:0]                      fwd_sel
);
  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    stall_req = 1'b0;
    fwd_sel   = SEL_W'(FWD_RF);
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (used && (src != '0) && vld_pipe[k] && (dst_pipe[k] == src)) begin
        if ((k >= 1) && (!ld_pipe[k] || (k >= LOAD_READY))) begin
          stall_req = 1'b0;
          fwd_sel   = SEL_W'(k + 1);
        end else begin
          stall_req = 1'b1;
          fwd_sel   = SEL_W'(FWD_RF);
        end
      end
    end
  end
endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Decode-stage interlock/forwarding controller: shift-register scoreboard of
// in-flight writes, per-source bypass selection, stall generation and counter.
module pipe_hazard_scoreboard
  import cpu_pipe_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_READY = 2,
  parameter int CNT_W      = 32,
  localparam int SEL_W     = $clog2(NUM_STAGES + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic [REG_ADDR_W-1:0]         id_dst_addr,
  input  logic                          id_reg_write,
  input  logic                          id_is_load,
  input  logic                          id_flush,
  output logic                          issue,
  output logic                          stall,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic [NUM_STAGES-1:0]         stage_valid,
  output logic [CNT_W-1:0]              stall_count
);
  logic [NUM_STAGES-1:0]                 vld_pipe;
  logic [NUM_STAGES-1:0]                 ld_pipe;
  logic [NUM_STAGES-1:0][REG_ADDR_W-1:0] dst_pipe;
  logic [NUM_SRC-1:0]                    src_stall;
  logic                                  new_vld;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_src_match #(
      .NUM_STAGES(NUM_STAGES),
      .REG_ADDR_W(REG_ADDR_W),
      .LOAD_READY(LOAD_READY),
      .SEL_W     (SEL_W)
    ) u_match (
      .src      (id_src_addr[i*REG_ADDR_W +: REG_ADDR_W]),
      .used     (id_src_used[i]),
      .vld_pipe (vld_pipe),
      .dst_pipe (dst_pipe),
      .ld_pipe  (ld_pipe),
      .stall_req(src_stall[i]),
      .fwd_sel  (fwd_sel[i*SEL_W +: SEL_W])
    );
  end

  // Flush and idle decode both suppress the stall so no bubble is counted.
  assign stall       = id_valid & ~id_flush & (|src_stall);
  assign issue       = id_valid & ~id_flush & ~stall;
  assign new_vld     = issue & id_reg_write & (id_dst_addr != '0);
  assign stage_valid = vld_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe    <= '0;
      ld_pipe     <= '0;
      dst_pipe    <= '0;
      stall_count <= '0;
    end else begin
      vld_pipe <= {vld_pipe[NUM_STAGES-2:0], new_vld};
      ld_pipe  <= {ld_pipe[NUM_STAGES-2:0], id_is_load};
      dst_pipe <= {dst_pipe[NUM_STAGES-2:0], id_dst_addr};
      if (stall && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
    end
  end
endmodule

// File: doc/pipe_hazard_scoreboard.md
Name: pipe_hazard_scoreboard

Overview:
Parametrised decode-stage interlock and forwarding controller, the successor to the fixed load-use detector in the decode stage. It tracks every in-flight register write in a shift-register scoreboard of NUM_STAGES entries (EX onward). For each decode source operand it produces a bypass select or a stall. Unlike the old detector it supports arbitrary pipeline depth, configurable load latency, per-source "used" qualification, r0 exclusion, flush priority, and a stall performance counter.

Parameters:
NUM_STAGES, 3, scoreboard depth; stage 0 = EX, NUM_STAGES-1 = WB
REG_ADDR_W, 5, register address width
NUM_SRC, 2, source operands per instruction
LOAD_READY, 2, first stage index at which load data is forwardable (1..NUM_STAGES-1)
CNT_W, 32, stall counter width
SEL_W, $clog2(NUM_STAGES+1), derived; width of one forward select

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
id_valid  in  1  valid instruction in decode
id_src_addr  in  NUM_SRC*REG_ADDR_W  source register addresses; src i at [i*REG_ADDR_W +: REG_ADDR_W]
id_src_used  in  NUM_SRC  source i is actually read
id_dst_addr  in  REG_ADDR_W  destination register
id_reg_write  in  1  instruction writes a register
id_is_load  in  1  instruction is a load
id_flush  in  1  squash decode instruction (branch/jump redirect)
issue  out  1  decode instruction advances into stage 0 this cycle
stall  out  1  hold fetch/decode, insert bubble
fwd_sel  out  NUM_SRC*SEL_W  per source: 0 = register file, k+1 = result of stage k
stage_valid  out  NUM_STAGES  debug: entry k holds a pending write
stall_count  out  CNT_W  cycles stalled since reset

Behaviour:
- Entry fields: valid, dst, is_load. Entries are written only when reg_write=1 and dst!=0. All other instructions occupy a slot as an invalid entry.
- Each clock, every entry shifts k -> k+1. Entry NUM_STAGES-1 retires; its write reaches the register file that same cycle.
- Stage 0 loads:
  - the decode instruction when issue=1;
  - otherwise an invalid bubble.
- issue = id_valid & ~stall & ~id_flush.
- Match for source i at stage k: id_src_used[i] & src!=0 & entry k valid & entry k dst == src.
- The youngest (lowest k) match decides; older matches to the same register are ignored.
- Youngest match at k is ready if k>=1 for non-loads, or k>=LOAD_READY for loads.
  - Ready: fwd_sel[i] = k+1.
  - Not ready: source requests a stall.
- No match: fwd_sel[i] = 0.
- stall = id_valid & ~id_flush & (any source requests stall). It is combinational from the current entries and decode inputs; there is no registered latency.
- fwd_sel is valid whenever issue=1; its value is don't-care otherwise.
- Flush wins over stall: when id_flush=1, stall=0, issue=0, and a bubble enters stage 0. Entries already in flight are not killed.
- id_valid=0: stall=0, issue=0, bubble enters stage 0.
- A load-use with LOAD_READY=L gives L stall cycles when the consumer directly follows the load (default 2: consumer decodes while the load is at k=0 and then k=1).
- A decode instruction writing the same register it reads matches only older entries. There is no self-match.
- stall_count increments by 1 on each cycle with stall=1 and saturates at all-ones.
- Reset: all entries invalid, stage_valid=0, stall_count=0. Combinationally this gives stall=0, issue=id_valid&~id_flush, fwd_sel=0. Reset asserted mid-stall discards all pending entries on the next edge.

Decomposition:
- Shared package cpu_pipe_pkg:
  - REG_ADDR_W default;
  - FWD_RF = 0 select encoding;
  - scoreboard entry struct (valid, dst, is_load).
- One sub-module, hazard_src_match: combinational, one instance per source. Scans the entries and returns {stall_req, fwd_sel}.
- The top holds the shift register, the issue/stall logic and the counter.

Test Plan:
- Reset, then id_valid=1, src=(3,4), used=11, no entries -> issue=1, stall=0, fwd_sel=(0,0), stall_count=0.
- ALU "add r5" issued, next cycle consumer reads r5 -> the add sits at k=0 and is not ready, so stall=1 for 1 cycle. Consumer then issues with fwd_sel[0]=2 (stage 1). stall_count=1.
- "lw r7" then consumer reading r7 with LOAD_READY=2 -> stall=1 for 2 cycles, then issue=1 with fwd_sel=3. Repeat with LOAD_READY=1 -> 1 stall cycle, fwd_sel=2.
- Writes to r9 at k=1 and k=2, consumer reads r9 -> fwd_sel=2 (youngest wins). Consumer reading r0, or with src_used=0 on the matching source -> fwd_sel=0, stall=0.
- Stall condition present with id_flush=1 in the same cycle -> stall=0, issue=0, stage_valid[0]=0 next cycle, stall_count unchanged.
- Reset asserted while a load is at k=0 and a consumer is stalled -> next cycle stage_valid=0, stall=0, stall_count=0. Force 2^CNT_W-1 stall cycles with CNT_W=4 -> counter holds at 15.
